// File: rtl/icebus_poll_scheduler.sv
// Round-robin poller for icebus motor boards. It keeps each board's latest current average and a stale flag.
// Define ICEBUS_SCHED_STATS_EN to add the saturating timeout_total output.
module icebus_poll_scheduler #(
    parameter int NUM_SLOTS      = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int GAP_CYCLES     = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        tx_valid,
    output logic [3:0]  tx_id,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [3:0]  rx_id,
    input  logic [31:0] rx_current,
    input  logic [3:0]  rd_idx,
    output logic [31:0] rd_current,
    output logic        rd_stale,
    output logic        busy,
    output logic        cycle_done,
`ifdef ICEBUS_SCHED_STATS_EN
    output logic [15:0] timeout_total,
`endif
    output logic [1:0]  dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [3:0]    PTR_LAST = 4'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_ptr;
    logic [TW-1:0]         r_to_cnt;
    logic [GW-1:0]         r_gap_cnt;
    logic                  r_cycle_done;
    logic [31:0]           r_cur [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  r_stale;

    logic w_match;
    logic w_expire;
    logic w_done;
    logic w_gap_end;
    logic w_wrap;

    // Frame handshake: a frame transfers on a rising edge where tx_valid and tx_ready are both high.
    // While in SEND, tx_valid and tx_id hold steady until that edge or until enable drops.
    // A response that matches on the expiry cycle itself is treated as a response.
    assign w_match   = (r_state == ST_WAIT) && rx_valid && (rx_id == r_ptr);
    assign w_expire  = (r_state == ST_WAIT) && (r_to_cnt == TO_LAST) && !w_match;
    assign w_done    = w_match || w_expire;
    assign w_gap_end = (r_state == ST_GAP) && (r_gap_cnt == GAP_LAST);
    assign w_wrap    = w_gap_end && (r_ptr == PTR_LAST);

    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    w_next = ST_WAIT;
                end else if (!enable) begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (w_done) begin
                    w_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_gap_end) begin
                    w_next = enable ? ST_SEND : ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_valid   = (r_state == ST_SEND);
        tx_id      = (r_state == ST_SEND) ? r_ptr : 4'd0;
        busy       = (r_state != ST_IDLE);
        cycle_done = r_cycle_done;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if ((r_state != ST_WAIT) || w_done) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gap_cnt <= '0;
        end else if ((r_state != ST_GAP) || w_gap_end) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
        end
    end

    // The pointer only moves once a transaction has fully finished its gap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr        <= 4'd0;
            r_cycle_done <= 1'b0;
        end else begin
            r_cycle_done <= w_wrap;
            if (w_gap_end) begin
                r_ptr <= (r_ptr == PTR_LAST) ? 4'd0 : r_ptr + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_cur[i] <= '0;
            end
            r_stale <= '1;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (r_ptr == 4'(i)) begin
                    if (w_match) begin
                        r_cur[i]   <= rx_current;
                        r_stale[i] <= 1'b0;
                    end else if (w_expire) begin
                        r_stale[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Indices beyond the table read as zero and not stale.
    always_comb begin
        rd_current = '0;
        rd_stale   = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (rd_idx == 4'(i)) begin
                rd_current = r_cur[i];
                rd_stale   = r_stale[i];
            end
        end
    end

`ifdef ICEBUS_SCHED_STATS_EN
    logic [15:0] r_to_total;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_total <= '0;
        end else if (w_expire && (r_to_total != 16'hFFFF)) begin
            r_to_total <= r_to_total + 16'd1;
        end
    end

    assign timeout_total = r_to_total;
`endif

endmodule

// File: tb/tb_icebus_poll_scheduler.sv
// Bench for icebus_poll_scheduler: board responder model plus scoreboard of expected slot-table results.
module tb_icebus_poll_scheduler;
  localparam int N   = 4;
  localparam int TO  = 200;
  localparam int GAP = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [3:0]  rx_id = 4'd0;
  logic [31:0] rx_current = 32'd0;
  logic [3:0]  rd_idx = 4'd0;
  logic        tx_valid;
  logic [3:0]  tx_id;
  logic [31:0] rd_current;
  logic        rd_stale;
  logic        busy;
  logic        cycle_done;
  logic [1:0]  dbg_state;
`ifdef ICEBUS_SCHED_STATS_EN
  logic [15:0] timeout_total;
`endif

  icebus_poll_scheduler #(
    .NUM_SLOTS(N),
    .TIMEOUT_CYCLES(TO),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .tx_valid(tx_valid),
    .tx_id(tx_id),
    .tx_ready(tx_ready),
    .rx_valid(rx_valid),
    .rx_id(rx_id),
    .rx_current(rx_current),
    .rd_idx(rd_idx),
    .rd_current(rd_current),
    .rd_stale(rd_stale),
    .busy(busy),
    .cycle_done(cycle_done),
`ifdef ICEBUS_SCHED_STATS_EN
    .timeout_total(timeout_total),
`endif
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected finish before 900000");
    $fatal(1, "watchdog expired");
  end

  // scoreboard entry: {wait_len[16], slot[4], stale[1], current[32]}
  logic [52:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          hs_cnt = 0;
  int          hs_cyc = 0;
  int          cd_cnt = 0;
  int          exp_cd = 0;
  int          pops = 0;
  int          exp_to = 0;
  logic [3:0]  exp_ptr = 4'd0;
  logic [3:0]  last_pop_slot = 4'd0;
  logic [31:0] exp_cur [16];
  logic        exp_stale [16];
  int          dly [16];
  logic [31:0] val [16];
  int          stray_slot = -1;
  int          stray_dly = 0;
  logic [3:0]  stray_id = 4'd0;
  bit          stray_fired = 1'b0;
  int          pend_at[$];
  logic [3:0]  pend_id[$];
  logic [31:0] pend_val[$];
  bit          pend_stray[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ptr = 4'd0;
    exp_to = 0;
    for (int i = 0; i < 16; i++) begin
      exp_cur[i] = 32'd0;
      exp_stale[i] = 1'b1;
    end
  endtask

  // On frame accept: predict the slot outcome and schedule the board's answer.
  task automatic push_expect(input logic [3:0] s);
    logic [52:0] e;
    if (dly[s] == 0 || dly[s] > TO) e = {16'(TO), s, 1'b1, exp_cur[s]};
    else e = {16'(dly[s]), s, 1'b0, val[s]};
    exp_q.push_back(e);
    if (dly[s] != 0) begin
      pend_at.push_back(cyc + dly[s] - 1);
      pend_id.push_back(s);
      pend_val.push_back(val[s]);
      pend_stray.push_back(1'b0);
    end
    if (stray_slot == int'(s)) begin
      pend_at.push_back(cyc + stray_dly - 1);
      pend_id.push_back(stray_id);
      pend_val.push_back(32'hDEAD_BEEF);
      pend_stray.push_back(1'b1);
    end
  endtask

  // One clock: observe the edge, score completions, then drive the next responses.
  task automatic tick();
    bit          hs;
    logic [1:0]  ps;
    logic [3:0]  hid;
    logic [52:0] e;
    int          k;
    hs  = tx_valid && tx_ready;
    ps  = dbg_state;
    hid = tx_id;
    @(posedge clk);
    #1;
    cyc++;
    rx_valid = 1'b0;
    if (hs) begin
      hs_cnt++;
      hs_cyc = cyc;
      check_eq("tx_id_at_accept", hid, exp_ptr);
      push_expect(hid);
    end
    if (stray_fired) begin
      stray_fired = 1'b0;
      check_eq("stray_still_wait", dbg_state, S_WAIT);
      rd_idx = stray_id;
      #1;
      check_eq("stray_no_write", rd_current, exp_cur[stray_id]);
    end
    if (ps == S_WAIT && dbg_state == S_GAP) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_completion", 1, 0);
      end else begin
        e = exp_q.pop_front();
        rd_idx = e[36:33];
        #1;
        check_eq("slot_current", rd_current, e[31:0]);
        check_eq("slot_stale", rd_stale, e[32]);
        check_eq("wait_len", cyc - hs_cyc, e[52:37]);
        exp_cur[e[36:33]] = e[31:0];
        exp_stale[e[36:33]] = e[32];
        if (e[32]) exp_to++;
        last_pop_slot = e[36:33];
        exp_ptr = (e[36:33] == 4'(N - 1)) ? 4'd0 : e[36:33] + 4'd1;
        pops++;
      end
    end
    if (cycle_done) begin
      cd_cnt++;
      check_eq("cycle_done_slot", last_pop_slot, N - 1);
    end
    k = -1;
    for (int i = 0; i < pend_at.size(); i++) if (pend_at[i] == cyc) k = i;
    if (k >= 0) begin
      rx_valid = 1'b1;
      rx_id = pend_id[k];
      rx_current = pend_val[k];
      stray_fired = pend_stray[k];
      pend_at.delete(k);
      pend_id.delete(k);
      pend_val.delete(k);
      pend_stray.delete(k);
    end
  endtask

  task automatic run_pops(input int n);
    int target;
    int budget;
    target = pops + n;
    budget = 4000;
    while (pops < target && budget > 0) begin
      tick();
      budget--;
    end
    if (pops < target) check_eq("pop_budget", pops, target);
  endtask

  task automatic run_round();
    run_pops(N);
    repeat (GAP) tick();
    exp_cd++;
    check_eq("cycle_done_count", cd_cnt, exp_cd);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tx_valid"}, tx_valid, 1'b0);
    check_eq({tag, "_tx_id"}, tx_id, 4'd0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_cycle_done"}, cycle_done, 1'b0);
    check_eq({tag, "_state"}, dbg_state, S_IDLE);
    for (int i = 0; i < N; i++) begin
      rd_idx = 4'(i);
      #1;
      check_eq({tag, "_cur"}, rd_current, 32'd0);
      check_eq({tag, "_stale"}, rd_stale, 1'b1);
    end
  endtask

  task automatic check_out_of_range(input string tag);
    rd_idx = 4'(N);
    #1;
    check_eq({tag, "_cur_n"}, rd_current, 32'd0);
    check_eq({tag, "_stale_n"}, rd_stale, 1'b0);
    rd_idx = 4'd15;
    #1;
    check_eq({tag, "_cur_15"}, rd_current, 32'd0);
    check_eq({tag, "_stale_15"}, rd_stale, 1'b0);
  endtask

  initial begin
    int h0;
    int b;
    model_reset();
    // reset state
    reset_n = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    check_out_of_range("reset_oob");
`ifdef ICEBUS_SCHED_STATS_EN
    check_eq("reset_timeout_total", timeout_total, 16'd0);
`endif
    reset_n = 1'b1;
    tick();

    // two full rounds, every board answers 100 cycles after accept
    for (int i = 0; i < N; i++) begin
      dly[i] = 100;
      val[i] = 32'h100 + 32'(i);
    end
    enable = 1'b1;
    tx_ready = 1'b1;
    run_round();
    run_round();
    for (int i = 0; i < N; i++) begin
      rd_idx = 4'(i);
      #1;
      check_eq("round_cur", rd_current, 32'h100 + 32'(i));
      check_eq("round_stale", rd_stale, 1'b0);
    end
    check_out_of_range("loaded_oob");

    // board 2 silent: times out after TO wait cycles, old value kept
    for (int i = 0; i < N; i++) begin
      dly[i] = 30;
      val[i] = 32'h200 + 32'(i);
    end
    dly[2] = 0;
    run_round();
    rd_idx = 4'd2;
    #1;
    check_eq("silent_cur_kept", rd_current, 32'h102);
    check_eq("silent_stale", rd_stale, 1'b1);
`ifdef ICEBUS_SCHED_STATS_EN
    check_eq("timeout_total_1", timeout_total, 16'd1);
`endif

    // answer on the exact expiry cycle wins; one cycle later is ignored
    for (int i = 0; i < N; i++) begin
      dly[i] = 30;
      val[i] = 32'h300 + 32'(i);
    end
    dly[0] = TO;
    dly[1] = TO + 1;
    run_round();
    rd_idx = 4'd0;
    #1;
    check_eq("exact_expiry_cur", rd_current, 32'h300);
    check_eq("exact_expiry_stale", rd_stale, 1'b0);
    rd_idx = 4'd1;
    #1;
    check_eq("late_cur_kept", rd_current, 32'h201);
    check_eq("late_stale", rd_stale, 1'b1);
`ifdef ICEBUS_SCHED_STATS_EN
    check_eq("timeout_total_2", timeout_total, 16'd2);
`endif

    // stray response for board 3 while polling slot 1
    for (int i = 0; i < N; i++) begin
      dly[i] = 20;
      val[i] = 32'h400 + 32'(i);
    end
    stray_slot = 1;
    stray_dly = 5;
    stray_id = 4'd3;
    run_round();
    stray_slot = -1;

    // transmitter stalls 10 cycles, then enable drops before accept
    tx_ready = 1'b0;
    h0 = hs_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("stall_tx_valid", tx_valid, 1'b1);
      check_eq("stall_tx_id", tx_id, exp_ptr);
      check_eq("stall_state", dbg_state, S_SEND);
    end
    enable = 1'b0;
    tick();
    check_eq("abort_tx_valid", tx_valid, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    tick();
    enable = 1'b1;
    tick();
    check_eq("resume_tx_valid", tx_valid, 1'b1);
    check_eq("resume_tx_id", tx_id, exp_ptr);
    tx_ready = 1'b1;
    run_pops(1);
    check_eq("single_accept", hs_cnt - h0, 1);

    // reset during WAIT aborts the transaction
    b = 0;
    while (dbg_state != S_WAIT && b < 100) begin
      tick();
      b++;
    end
    check_eq("reach_wait", dbg_state, S_WAIT);
    repeat (5) tick();
    reset_n = 1'b0;
    enable = 1'b0;
    tick();
    check_reset_outputs("midwait_reset");
    model_reset();
    reset_n = 1'b1;
    repeat (30) tick();
    check_eq("post_reset_state", dbg_state, S_IDLE);
    rd_idx = 4'd1;
    #1;
    check_eq("post_reset_cur", rd_current, 32'd0);
    check_eq("post_reset_stale", rd_stale, 1'b1);
`ifdef ICEBUS_SCHED_STATS_EN
    check_eq("post_reset_timeout_total", timeout_total, 16'd0);
`endif

    // polling restarts from slot 0
    enable = 1'b1;
    run_pops(1);
    check_eq("final_cycle_done_count", cd_cnt, exp_cd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/icebus_poll_scheduler.md
ICEBUS_POLL_SCHEDULER -- requirements
Module: icebus_poll_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of motor boards polled round-robin (2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, clock cycles allowed for a response before the slot is declared timed out.
REQ-003 SHALL have parameter GAP_CYCLES, default 16, idle bus cycles inserted between transactions (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  host run bit; polling proceeds while high.
REQ-007 SHALL have port tx_valid  output  1  request to icebus transmitter to send a poll frame.
REQ-008 SHALL have port tx_id  output  4  board ID of the frame being requested.
REQ-009 SHALL have port tx_ready  input  1  transmitter accepts frame when tx_valid and tx_ready both high.
REQ-010 SHALL have port rx_valid  input  1  one-cycle pulse: decoded response available.
REQ-011 SHALL have port rx_id  input  4  board ID carried in the response.
REQ-012 SHALL have port rx_current  input  32  current-average field carried in the response.
REQ-013 SHALL have port rd_idx  input  4  host read index into the slot table.
REQ-014 SHALL have port rd_current  output  32  stored current average of slot rd_idx, combinational read.
REQ-015 SHALL have port rd_stale  output  1  slot rd_idx last transaction timed out.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port cycle_done  output  1  one-cycle pulse after the last slot of a round completes.

Function
REQ-018 SHALL implement states IDLE, SEND, WAIT, GAP.
REQ-019 IDLE -> SEND when enable high; slot pointer starts at 0 after reset, otherwise resumes at next slot.
REQ-020 SEND: tx_valid=1, tx_id=slot pointer; tx_valid and tx_id SHALL hold stable until tx_ready sampled high; then -> WAIT with timeout counter cleared.
REQ-021 WAIT: rx_valid with rx_id==pointer SHALL write rx_current to the slot, clear its stale bit, -> GAP.
REQ-022 WAIT: rx_valid with rx_id!=pointer SHALL be ignored (no table write, no state change).
REQ-023 WAIT: counter reaching TIMEOUT_CYCLES-1 without a matching response SHALL set the slot's stale bit, keep its old current value, -> GAP.
REQ-024 Matching response in the same cycle as timeout expiry SHALL win: value stored, stale cleared.
REQ-025 GAP: count GAP_CYCLES, then advance pointer; pointer wraps NUM_SLOTS-1 -> 0 and cycle_done pulses on that wrap.
REQ-026 After GAP: -> SEND if enable high, else -> IDLE.
REQ-027 enable deasserted in SEND before handshake SHALL drop tx_valid and -> IDLE without advancing pointer; deasserted in WAIT/GAP SHALL let the transaction complete.
REQ-028 rx_valid in IDLE, SEND or GAP SHALL be ignored.
REQ-029 rd_idx >= NUM_SLOTS SHALL return rd_current=0, rd_stale=0.

Reset
REQ-030 On reset_n low: state IDLE, pointer 0, tx_valid=0, tx_id=0, busy=0, cycle_done=0, all slot currents 0, all stale bits 1, counters 0.
REQ-031 Reset mid-transaction SHALL abort immediately; no table write from the aborted transaction.

Configuration
REQ-032 With ICEBUS_SCHED_STATS_EN defined SHALL add output timeout_total (16 bit) counting timeouts since reset, saturating at 0xFFFF; without it the port and counter SHALL be absent.

Verification
REQ-033 NUM_SLOTS=4, enable=1, tx_ready=1, each board answers 100 cycles after accept with current 0x100+id -> table holds 0x100..0x103, all stale 0, cycle_done once per round.
REQ-034 Board 2 never answers, TIMEOUT_CYCLES=200 -> slot 2 stale=1 after 200 WAIT cycles, old value kept, poll continues to slot 3.
REQ-035 tx_ready held low 10 cycles in SEND -> tx_valid and tx_id=current slot stable all 10 cycles, single accept.
REQ-036 Response with rx_id=3 while polling slot 1 -> no write to slot 3 or 1, still WAIT.
REQ-037 Matching response on exact timeout cycle -> value stored, stale=0; with ICEBUS_SCHED_STATS_EN timeout_total unchanged.
REQ-038 reset_n pulsed low during WAIT -> all outputs at reset values next edge, stale bits all 1, response arriving after release ignored.
